// File: rtl/delay_chain_test_ctrl.sv
// Self-test sequencer for a long shift-register delay chain: flush, inject a marker, time it, check.
// Define DELAY_CHAIN_ERR_CNT_EN to add the run_count/err_count statistics outputs.
module delay_chain_test_ctrl #(
   parameter int unsigned DEPTH         = 41984,
   parameter int unsigned TIMEOUT_EXTRA = 16,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             chain_out,
   output logic             chain_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] latency
`ifdef DELAY_CHAIN_ERR_CNT_EN
   ,
   output logic [15:0]      run_count,
   output logic [7:0]       err_count
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] EXPECTED   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(DEPTH + TIMEOUT_EXTRA);

   typedef enum logic [2:0] {
      StIdle,
      StFlush,
      StInject,
      StWait,
      StCheck
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             chain_in_q, chain_in_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] latency_q, latency_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      chain_in_d = 1'b0;
      done_d     = 1'b0;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      latency_d  = latency_q;

      if (abort && (state_q != StIdle)) begin
         // Results were cleared when the run started; keep them cleared.
         state_d   = StIdle;
         cnt_d     = '0;
         pass_d    = 1'b0;
         timeout_d = 1'b0;
         latency_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  state_d   = StFlush;
                  cnt_d     = '0;
                  pass_d    = 1'b0;
                  timeout_d = 1'b0;
                  latency_d = '0;
               end
            end
            StFlush: begin
               if (cnt_q == FLUSH_LAST) begin
                  // chain_in is registered, so the marker is launched on entry to StInject.
                  state_d    = StInject;
                  cnt_d      = '0;
                  chain_in_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            StInject: begin
               state_d = StWait;
               cnt_d   = cnt_q + CNT_ONE;
            end
            StWait: begin
               if (chain_out) begin
                  state_d   = StCheck;
                  latency_d = cnt_q;
               end else if (cnt_q == WAIT_LIMIT) begin
                  state_d   = StIdle;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
                  pass_d    = 1'b0;
                  latency_d = '1;
                  done_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            StCheck: begin
               // A marker still high here was stretched to more than one cycle.
               state_d = StIdle;
               cnt_d   = '0;
               pass_d  = (latency_q == EXPECTED) && !chain_out;
               done_d  = 1'b1;
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         chain_in_q <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         latency_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         chain_in_q <= chain_in_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         latency_q  <= latency_d;
      end
   end

   assign chain_in = chain_in_q;
   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign pass     = pass_q;
   assign timeout  = timeout_q;
   assign latency  = latency_q;

`ifdef DELAY_CHAIN_ERR_CNT_EN
   logic [15:0] run_cnt_q;
   logic [7:0]  err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q <= '0;
         err_cnt_q <= '0;
      end else if (done_d) begin
         run_cnt_q <= run_cnt_q + 16'd1;
         if (!pass_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign run_count = run_cnt_q;
   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_delay_chain_test_ctrl.sv
// Bench for delay_chain_test_ctrl with a small configurable chain model and a cycle-index model.
module tb_delay_chain_test_ctrl;

   localparam int unsigned D  = 8;
   localparam int unsigned TE = 4;
   localparam int unsigned W  = 16;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         chain_out;
   logic         chain_in, busy, done, pass, timeout;
   logic [W-1:0] latency;
`ifdef DELAY_CHAIN_ERR_CNT_EN
   logic [15:0]  run_count;
   logic [7:0]   err_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Chain model: 0 = stuck low, 1 = D regs, 2 = D-1 regs, 3 = D regs with a 2-cycle marker
   logic [15:0] sr   = '0;
   int          mode = 1;

   delay_chain_test_ctrl #(
      .DEPTH         (D),
      .TIMEOUT_EXTRA (TE),
      .CNT_W         (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .chain_out (chain_out),
      .chain_in  (chain_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .timeout   (timeout),
      .latency   (latency)
`ifdef DELAY_CHAIN_ERR_CNT_EN
      ,
      .run_count (run_count),
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) sr <= {sr[14:0], chain_in};

   always_comb begin
      chain_out = 1'b0;
      case (mode)
         1: chain_out = sr[D-1];
         2: chain_out = sr[D-2];
         3: chain_out = sr[D-1] | sr[D];
         default: chain_out = 1'b0;
      endcase
   end

   // Model: m_k is the cycle index since the accepted start (1 = first flush cycle).
   bit           m_active = 1'b0;
   int           m_k = 0, m_mark = 0, m_w = 0;
   logic         ex_ci = 0, ex_busy = 0, ex_done = 0, ex_pass = 0, ex_to = 0;
   logic [W-1:0] ex_lat = '0;
   int           ex_runs = 0, ex_errs = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 1'b0; m_k = 0; m_mark = 0;
         ex_ci = 0; ex_busy = 0; ex_done = 0; ex_pass = 0; ex_to = 0; ex_lat = '0;
         ex_runs = 0; ex_errs = 0;
      end
      n_checks++;
      if ({chain_in, busy, done, pass, timeout, latency} !==
          {ex_ci, ex_busy, ex_done, ex_pass, ex_to, ex_lat}) begin
         n_errors++;
         $display("FAIL cycle t=%0t got ci=%b busy=%b done=%b pass=%b to=%b lat=%0d want ci=%b busy=%b done=%b pass=%b to=%b lat=%0d",
                  $time, chain_in, busy, done, pass, timeout, latency,
                  ex_ci, ex_busy, ex_done, ex_pass, ex_to, ex_lat);
      end
`ifdef DELAY_CHAIN_ERR_CNT_EN
      n_checks++;
      if ({run_count, err_count} !== {16'(ex_runs), 8'(ex_errs)}) begin
         n_errors++;
         $display("FAIL counters t=%0t got run=%0d err=%0d want run=%0d err=%0d",
                  $time, run_count, err_count, ex_runs, ex_errs);
      end
`endif
      if (rst_n) begin
         ex_done = 1'b0;
         if (m_active && abort) begin
            m_active = 1'b0; ex_pass = 0; ex_to = 0; ex_lat = '0;
         end else if (!m_active) begin
            if (start && !abort) begin
               m_active = 1'b1; m_k = 0; m_mark = 0; ex_pass = 0; ex_to = 0; ex_lat = '0;
            end
         end else if (m_mark != 0) begin
            ex_pass  = (m_mark == int'(D)) && !chain_out;
            ex_done  = 1'b1;
            m_active = 1'b0;
         end else if (m_k >= int'(D) + 2) begin
            m_w = m_k - int'(D) - 1;
            if (chain_out) begin
               m_mark = m_w;
               ex_lat = W'(m_w);
            end else if (m_w == int'(D + TE)) begin
               ex_to = 1; ex_pass = 0; ex_lat = '1; ex_done = 1; m_active = 1'b0;
            end
         end
         if (m_active) m_k++;
         ex_busy = m_active;
         ex_ci   = m_active && (m_k == int'(D) + 1);
         if (ex_done) begin
            ex_runs = (ex_runs + 1) % 65536;
            if (!ex_pass && ex_errs < 255) ex_errs++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Returns in cycle k=1 of the new run.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Advances until done; n is the cycle index at which done was seen, ci the first chain_in cycle.
   task automatic wait_done(input string name, input int n0, output int n, output int ci);
      n  = n0;
      ci = -1;
      while (!done && n < 200) begin
         if (chain_in && ci < 0) ci = n;
         tick();
         n++;
      end
      chk({name, "_done_seen"}, done, 1);
   endtask

   task automatic run(input string name, input int md, input int exp_n, input bit exp_pass,
                      input bit exp_to, input logic [W-1:0] exp_lat);
      int n, ci;
      mode = md;
      pulse_start();
      wait_done(name, 1, n, ci);
      chk({name, "_cycles"}, n, exp_n);
      chk({name, "_pass"}, pass, exp_pass);
      chk({name, "_timeout"}, timeout, exp_to);
      chk({name, "_latency"}, latency, exp_lat);
   endtask

   initial begin
      int n, ci, seen;
      #1 rst_n = 1'b0;
      tick(); tick(); tick();
      chk("reset_busy", busy, 0);
      chk("reset_chain_in", chain_in, 0);
      chk("reset_latency", latency, 0);
      rst_n = 1'b1;
      tick();

      // Ideal chain, with an extra start while busy that must be ignored.
      mode = 1;
      pulse_start();
      repeat (4) tick();
      pulse_start();
      wait_done("ideal", 6, n, ci);
      chk("ideal_cycles", n, 19);
      chk("ideal_inject_cycle", ci, 9);
      chk("ideal_pass", pass, 1);
      chk("ideal_timeout", timeout, 0);
      chk("ideal_latency", latency, 8);
      repeat (3) tick();
      chk("ideal_held_pass", pass, 1);
      chk("ideal_held_latency", latency, 8);

      run("short", 2, 18, 0, 0, 16'd7);
      run("stuck", 0, 22, 0, 1, 16'hFFFF);
      run("stretch", 3, 19, 0, 0, 16'd8);
`ifdef DELAY_CHAIN_ERR_CNT_EN
      chk("cnt_run_after4", run_count, 4);
      chk("cnt_err_after4", err_count, 3);
`endif

      // Abort in WAIT count 3.
      mode = 1;
      pulse_start();
      repeat (11) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass, 0);
      chk("abort_latency", latency, 0);
      seen = 0;
      repeat (15) begin
         tick();
         if (done || busy) seen = 1;
      end
      chk("abort_no_done", seen, 0);

      // start and abort together in IDLE: stay idle.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_wins", busy, 0);

      // Reset mid-flush.
      pulse_start();
      repeat (3) tick();
      chk("flush_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_busy", busy, 0);
      chk("rst_async_outs", {chain_in, done, pass, timeout}, 0);
      chk("rst_async_latency", latency, 0);
      tick();
      rst_n = 1'b1;
      tick();

      run("recover", 1, 19, 1, 0, 16'd8);
`ifdef DELAY_CHAIN_ERR_CNT_EN
      run("cnt_fail", 2, 18, 0, 0, 16'd7);
      run("cnt_pass", 1, 19, 1, 0, 16'd8);
      chk("cnt_run_3", run_count, 3);
      chk("cnt_err_1", err_count, 1);
      mode = 2;
      repeat (300) begin
         pulse_start();
         wait_done("sat", 1, n, ci);
      end
      chk("cnt_err_sat", err_count, 255);
      chk("cnt_run_303", run_count, 303);
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
